fetch_unit: RTL and testbench

Instruction-fetch and PC-sequencing block at the front of the five-stage pipeline. It consumes the `branching_out_t` redirect and stall bundle issued by the branch-resolution logic, and owns the PC register, the instruction-memory request/response handshake, a one-entry response skid buffer and the IF/DEC pipeline register. It delivers `PCIF` (PC of the instruction in decode) and `PCDEC` (PC of the instruction in execute) back to branch resolution.

---
 rtl/core_types_pkg.sv | 31 +++
 rtl/fetch_skid_buf.sv | 35 +++
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: the branch-resolution bundle, fetch FSM encoding and
// the redirect-target helper used by the front end.
package core_types_pkg;

  typedef struct packed {
    logic        flush;
    logic        hold;
    logic        branch;
    logic        bypass;
    logic [31:0] PCnext;
    logic [31:0] PCcurrent;
  } branching_out_t;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t ISSUE = 1'b0;
  localparam fetch_state_t WAIT  = 1'b1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Absolute JALR target wins over the PC-relative branch; bit 0 is never fetchable.
  function automatic logic [31:0] redirectTarget(input branching_out_t b);
    logic [31:0] t;
    if (b.bypass) begin
      t = b.PCnext;
    end else begin
      t = b.PCcurrent + b.PCnext;
    end
    return {t[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for an instruction response that arrives while
// the IF/DEC register is frozen.
module fetch_skid_buf
  import core_types_pkg::*;
(
  input  logic        Clock,
  input  logic        nReset,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  // Clear beats load beats drain.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= 32'h0000_0000;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instrIn;
      pc    <= pcIn;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC sequencing, single-outstanding instruction-memory handshake and the
// IF/DEC pipeline register for the front of the five-stage core.
module fetch_unit
  import core_types_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic           Clock,
  input  logic           nReset,
  input  branching_out_t br,
  output logic           imem_req,
  output logic [31:0]    imem_addr,
  input  logic           imem_gnt,
  input  logic           imem_rvalid,
  input  logic [31:0]    imem_rdata,
  output logic [31:0]    instrIF,
  output logic           validIF,
  output logic [31:0]    PCIF,
  output logic [31:0]    PCDEC,
  output logic           validDEC
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  reqAddr;
  logic         stale;

  logic         redirect;
  logic [31:0]  target;
  logic         respUse;
  logic         ifAdvance;
  logic         skidValid;
  logic [31:0]  skidInstr;
  logic [31:0]  skidPc;

  assign redirect  = br.bypass | br.branch;
  assign target    = redirectTarget(br);
  assign respUse   = (state == WAIT) & imem_rvalid & ~stale & ~redirect & ~br.flush;
  assign ifAdvance = ~br.flush & ~redirect & ~br.hold;

  assign imem_req  = nReset & (state == ISSUE) & ~skidValid;
  assign imem_addr = pc;

  fetch_skid_buf uSkid (
    .Clock   (Clock),
    .nReset  (nReset),
    .load    (respUse & br.hold),
    .drain   (ifAdvance & skidValid),
    .clear   (redirect | br.flush),
    .instrIn (imem_rdata),
    .pcIn    (reqAddr),
    .instr   (skidInstr),
    .pc      (skidPc),
    .valid   (skidValid)
  );

  // Fetch FSM: a redirect overtaking an in-flight request marks it stale.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= ISSUE;
      pc      <= RESET_PC;
      reqAddr <= RESET_PC;
      stale   <= 1'b0;
    end else begin
      case (state)
        ISSUE: begin
          if (imem_req && imem_gnt) begin
            state   <= WAIT;
            reqAddr <= pc;
            stale   <= redirect;
            pc      <= redirect ? target : pc + 32'd4;
          end else if (redirect) begin
            pc <= target;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state <= ISSUE;
            stale <= 1'b0;
          end else if (redirect) begin
            stale <= 1'b1;
          end
          if (redirect) begin
            pc <= target;
          end
        end
        default: begin
          state <= ISSUE;
          stale <= 1'b0;
        end
      endcase
    end
  end

  // IF/DEC and DEC/EX bookkeeping; skid content always precedes a new response.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      instrIF  <= NOP;
      validIF  <= 1'b0;
      PCIF     <= 32'h0000_0000;
      PCDEC    <= 32'h0000_0000;
      validDEC <= 1'b0;
    end else if (br.flush) begin
      instrIF  <= NOP;
      validIF  <= 1'b0;
      validDEC <= 1'b0;
    end else if (redirect) begin
      PCDEC    <= PCIF;
      validDEC <= validIF;
      instrIF  <= NOP;
      validIF  <= 1'b0;
    end else if (br.hold) begin
      validDEC <= 1'b0;
    end else begin
      PCDEC    <= PCIF;
      validDEC <= validIF;
      if (skidValid) begin
        instrIF <= skidInstr;
        PCIF    <= skidPc;
        validIF <= 1'b1;
      end else if (respUse) begin
        instrIF <= imem_rdata;
        PCIF    <= reqAddr;
        validIF <= 1'b1;
      end else begin
        instrIF <= NOP;
        validIF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a bench-side memory model feeds a
// scoreboard of expected {PC, instruction} pairs, plus directed sequences.
module tb_fetch_unit;
  import core_types_pkg::*;

  logic           Clock = 1'b0;
  logic           nReset;
  branching_out_t br;
  logic           imem_req;
  logic [31:0]    imem_addr;
  logic           imem_gnt;
  logic           imem_rvalid;
  logic [31:0]    imem_rdata;
  logic [31:0]    instrIF;
  logic           validIF;
  logic [31:0]    PCIF;
  logic [31:0]    PCDEC;
  logic           validDEC;

  always #5 Clock = ~Clock;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .Clock(Clock), .nReset(nReset), .br(br),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instrIF(instrIF), .validIF(validIF), .PCIF(PCIF),
    .PCDEC(PCDEC), .validDEC(validDEC)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;
  typedef struct {
    logic flush; logic bypass; logic branch;
    logic [31:0] nx; logic [31:0] cur; logic [31:0] exp;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  sb_t         sbq[$];
  logic        pend, staleB, skidB, gntRand, prevV;
  sb_t         skidE;
  int          cntLeft, memLat;
  logic [31:0] pendAddr, prevPC;

  function automatic logic [31:0] memData(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive controls and memory, model acceptance, then score IF/DEC.
  task automatic step(input logic fl, input logic ho, input logic brn, input logic byp,
                      input logic [31:0] nx, input logic [31:0] cur);
    logic redir, grantNow, accept;
    logic [31:0] gAddr;
    sb_t e;
    br.flush = fl; br.hold = ho; br.branch = brn; br.bypass = byp;
    br.PCnext = nx; br.PCcurrent = cur;
    imem_rvalid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (pend) begin
      if (cntLeft <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata = memData(pendAddr);
      end else begin
        cntLeft--;
      end
    end
    imem_gnt = gntRand ? 1'($urandom_range(0, 1)) : 1'b1;
    #3;
    redir = byp | brn;
    grantNow = imem_req & imem_gnt;
    gAddr = imem_addr;
    accept = imem_rvalid & ~(staleB | redir | fl);
    if (redir || fl) begin
      skidB = 1'b0;
    end else if (!ho && skidB) begin
      sbq.push_back(skidE);
      skidB = 1'b0;
    end
    if (imem_rvalid) begin
      pend = 1'b0;
      staleB = 1'b0;
      if (accept) begin
        e.pc = pendAddr;
        e.instr = memData(pendAddr);
        if (ho) begin
          skidB = 1'b1;
          skidE = e;
        end else begin
          sbq.push_back(e);
        end
      end
    end else if (pend && redir) begin
      staleB = 1'b1;
    end
    @(posedge Clock);
    #1;
    if (grantNow) begin
      pend = 1'b1;
      pendAddr = gAddr;
      staleB = redir;
      cntLeft = memLat;
    end
    if (validIF && !(prevV && prevPC == PCIF)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got pc %h, expected no new instruction", PCIF);
      end else begin
        e = sbq.pop_front();
        chk("sb_pc", PCIF, e.pc);
        chk("sb_instr", instrIF, e.instr);
      end
    end
    prevV = validIF;
    prevPC = PCIF;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic waitReq(input string name);
    int n = 0;
    while (!imem_req && n < 20) begin
      idle();
      n++;
    end
    total++;
    if (!imem_req) begin
      bad++;
      $display("FAIL %s: got no imem_req within 20 cycles, expected a request", name);
    end
  endtask

  vec_t        vecs[7];
  logic [31:0] t;
  int          r;

  initial begin
    nReset = 1'b0; br = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pend = 1'b0; staleB = 1'b0; skidB = 1'b0; gntRand = 1'b0; memLat = 1; cntLeft = 0;
    prevV = 1'b0; prevPC = 32'h0; pendAddr = 32'h0;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000, 32'h0000_2000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0000_0040, 32'h0000_0030};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0004, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_1235, 32'h0000_0000, 32'h0000_1234};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'h0000_0100, 32'h0000_0800};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0002, 32'h0000_1001, 32'h0000_1002};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0006, 32'h0000_0200, 32'h0000_0206};

    repeat (2) @(posedge Clock);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_instrIF", instrIF, 32'h0000_0013);
    chk("rst_validIF", 32'(validIF), 32'd0);
    chk("rst_PCIF", PCIF, 32'h0);
    chk("rst_PCDEC", PCDEC, 32'h0);
    chk("rst_validDEC", 32'(validDEC), 32'd0);
    #1 nReset = 1'b1;
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'h0000_0100);

    // Zero-wait latency and DEC follow-on.
    idle();
    chk("lat_req_wait", 32'(imem_req), 32'd0);
    chk("lat_validIF0", 32'(validIF), 32'd0);
    idle();
    chk("lat_validIF", 32'(validIF), 32'd1);
    chk("lat_PCIF", PCIF, 32'h0000_0100);
    chk("lat_addr2", imem_addr, 32'h0000_0104);
    chk("lat_validDEC0", 32'(validDEC), 32'd0);
    idle();
    chk("lat_validDEC", 32'(validDEC), 32'd1);
    chk("lat_PCDEC", PCDEC, 32'h0000_0100);
    idle();
    chk("lat_PCIF2", PCIF, 32'h0000_0104);

    // Load-use hold across the response: IF/DEC frozen, response parked.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      chk("hold_PCIF", PCIF, 32'h0000_0104);
      chk("hold_instrIF", instrIF, memData(32'h0000_0104));
      chk("hold_validDEC", 32'(validDEC), 32'd0);
      chk("hold_req", 32'(imem_req), 32'd0);
    end
    idle();
    chk("drain_PCIF", PCIF, 32'h0000_0108);
    chk("drain_validDEC", 32'(validDEC), 32'd1);
    chk("drain_PCDEC", PCDEC, 32'h0000_0104);
    chk("drain_addr", imem_addr, 32'h0000_010C);

    // Flush with a request outstanding: the late response is stale.
    memLat = 2;
    idle();
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h0);
    chk("fl_validIF", 32'(validIF), 32'd0);
    chk("fl_validDEC", 32'(validDEC), 32'd0);
    chk("fl_addr", imem_addr, 32'h0000_2000);
    memLat = 1;
    idle();
    chk("fl_req", 32'(imem_req), 32'd1);
    chk("fl_stale_dropped", 32'(validIF), 32'd0);
    idle();
    idle();
    chk("fl_target_PCIF", PCIF, 32'h0000_2000);

    // Redirect target table, each redirect coinciding with a grant.
    for (int i = 0; i < 7; i++) begin
      waitReq("tbl_wait");
      step(vecs[i].flush, ~vecs[i].flush, vecs[i].branch, vecs[i].bypass, vecs[i].nx, vecs[i].cur);
      chk("tbl_addr", imem_addr, vecs[i].exp);
      chk("tbl_validIF", 32'(validIF), 32'd0);
      if (vecs[i].flush) chk("tbl_validDEC", 32'(validDEC), 32'd0);
      repeat (4) idle();
    end

    // Randomised traffic: variable grant/latency, holds, redirects.
    gntRand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      memLat = $urandom_range(1, 3);
      t = $urandom;
      t[1:0] = 2'b00;
      if (r < 5) step(1'b1, 1'b0, 1'b0, 1'b1, t, 32'h0);
      else if (r < 10) step(1'b0, 1'b1, 1'b1, 1'b0, {20'h0, t[11:0]}, t);
      else if (r < 30) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      else idle();
    end
    gntRand = 1'b0;
    memLat = 1;
    repeat (10) idle();
    chk("rand_sb_empty", 32'(sbq.size()), 32'd0);

    // Asynchronous reset while waiting on memory.
    memLat = 2;
    waitReq("rst_wait");
    idle();
    chk("mid_req_wait", 32'(imem_req), 32'd0);
    #2 nReset = 1'b0;
    #1;
    chk("mid_req", 32'(imem_req), 32'd0);
    chk("mid_validIF", 32'(validIF), 32'd0);
    chk("mid_instrIF", instrIF, 32'h0000_0013);
    chk("mid_PCIF", PCIF, 32'h0);
    chk("mid_PCDEC", PCDEC, 32'h0);
    chk("mid_validDEC", 32'(validDEC), 32'd0);
    pend = 1'b0; staleB = 1'b0; skidB = 1'b0; sbq.delete();
    prevV = 1'b0; prevPC = 32'h0; memLat = 1;
    @(posedge Clock);
    #2 nReset = 1'b1;
    #1;
    chk("mid_rel_req", 32'(imem_req), 32'd1);
    chk("mid_rel_addr", imem_addr, 32'h0000_0100);
    idle();
    idle();
    chk("mid_rel_PCIF", PCIF, 32'h0000_0100);
    repeat (3) idle();
    chk("end_sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected earlier finish");
    $fatal(1, "watchdog");
  end

endmodule
